// File: rtl/ext_mem_pkg.sv
// Shared command field positions, tag format and beat-count helper for the
// external-memory read arbiter.
package ext_mem_pkg;

    localparam int unsigned CMD_W     = 72;
    localparam int unsigned BTT_LSB   = 0;
    localparam int unsigned BTT_MSB   = 22;
    localparam int unsigned SADDR_LSB = 32;
    localparam int unsigned SADDR_MSB = 63;
    localparam int unsigned BTT_W     = BTT_MSB - BTT_LSB + 1;
    localparam int unsigned BTT_XW    = BTT_W + 1;
    localparam int unsigned BEATS_W   = 21;
    localparam int unsigned OWNER_W   = 3;

    typedef struct packed {
        logic [OWNER_W-1:0] owner;
        logic [BEATS_W-1:0] beats_m1;
    } tag_t;

    // Beats minus one for a transfer; a zero-byte transfer still returns one beat.
    function automatic logic [BEATS_W-1:0] beats_m1(input logic [BTT_W-1:0] btt,
                                                    input int unsigned bytes_per_beat);
        logic [BTT_XW-1:0] beats;
        if (btt == '0) return '0;
        beats = (BTT_XW'(btt) + BTT_XW'(bytes_per_beat) - BTT_XW'(1)) / BTT_XW'(bytes_per_beat);
        return BEATS_W'(beats - BTT_XW'(1));
    endfunction

endpackage

// File: rtl/ext_mem_tag_fifo.sv
// In-order tag FIFO, first-word-fall-through so the head steers return beats
// in the same cycle they arrive.
module ext_mem_tag_fifo
    import ext_mem_pkg::*;
#(
    parameter int unsigned AW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  tag_t        push_tag,
    input  logic        pop,
    output tag_t        head,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    localparam int unsigned DEPTH = 1 << AW;

    tag_t          mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ext_mem_read_arbiter.sv
// Round-robin share of the external-memory read command channel; returned
// beats are steered to the owner recorded in the in-order tag FIFO.
module ext_mem_read_arbiter
    import ext_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_AW     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_cmd_valid,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd_data,
    output logic [NUM_REQ-1:0]       req_cmd_ready,
    output logic                     mem_cmd_valid,
    output logic [CMD_W-1:0]         mem_cmd_data,
    input  logic                     mem_cmd_ready,
    input  logic [DATA_WIDTH-1:0]    mem_rd_data,
    input  logic                     mem_rd_valid,
    output logic                     mem_rd_ready,
    output logic [DATA_WIDTH-1:0]    req_rd_data,
    output logic [NUM_REQ-1:0]       req_rd_valid,
    input  logic [NUM_REQ-1:0]       req_rd_ready,
    output logic [TAG_AW:0]          outstanding
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;
    localparam int unsigned BPB   = DATA_WIDTH / 8;

    typedef enum logic {ARB, ISSUE} state_t;

    state_t             state;
    logic               run;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   rr_next;
    logic               grant_any;
    logic               can_grant;
    logic [CMD_W-1:0]   grant_cmd;
    tag_t               push_tag;
    tag_t               head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               rd_hs;
    logic [BEATS_W-1:0] beat_cnt;

    // First valid requester at or after rr_ptr, found on a rotated copy.
    always_comb begin
        logic [NUM_REQ-1:0] rot;
        logic [SUM_W-1:0]   off;
        logic [SUM_W-1:0]   sum;
        logic [SUM_W-1:0]   nsum;
        rot = NUM_REQ'({req_cmd_valid, req_cmd_valid} >> rr_ptr);
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = SUM_W'(k);
        end
        grant_any = |rot;
        sum = SUM_W'(rr_ptr) + off;
        if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
        grant_idx = PTR_W'(sum);
        nsum = sum + SUM_W'(1);
        if (nsum >= SUM_W'(NUM_REQ)) nsum = nsum - SUM_W'(NUM_REQ);
        rr_next = PTR_W'(nsum);
    end

    assign can_grant = (state == ARB) && run && !fifo_full && grant_any;

    always_comb begin
        req_cmd_ready = '0;
        grant_cmd     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                grant_cmd        = req_cmd_data[CMD_W*i +: CMD_W];
                req_cmd_ready[i] = can_grant;
            end
        end
        push_tag.owner    = OWNER_W'(grant_idx);
        push_tag.beats_m1 = beats_m1(grant_cmd[BTT_MSB:BTT_LSB], BPB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARB;
            run           <= 1'b0;
            rr_ptr        <= '0;
            mem_cmd_valid <= 1'b0;
            mem_cmd_data  <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                ARB: begin
                    if (can_grant) begin
                        mem_cmd_data  <= grant_cmd;
                        mem_cmd_valid <= 1'b1;
                        rr_ptr        <= rr_next;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        state         <= ARB;
                    end
                end
            endcase
        end
    end

    // Return path: pure pass-through to the head owner; nothing claims data while empty.
    always_comb begin
        req_rd_valid = '0;
        mem_rd_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!fifo_empty && (head.owner == OWNER_W'(i))) begin
                req_rd_valid[i] = mem_rd_valid;
                mem_rd_ready    = req_rd_ready[i];
            end
        end
    end

    assign req_rd_data = mem_rd_data;
    assign rd_hs       = mem_rd_valid && mem_rd_ready;
    assign pop         = rd_hs && (beat_cnt == head.beats_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (rd_hs) begin
            beat_cnt <= pop ? '0 : beat_cnt + BEATS_W'(1);
        end
    end

    ext_mem_tag_fifo #(
        .AW (TAG_AW)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (can_grant),
        .push_tag (push_tag),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (outstanding)
    );

endmodule
